ysyx_22050039_lsu: RTL and testbench

Multi-cycle load/store unit behind the execute stage of the 64-bit RISC-V core. Takes the effective address computed by the EXU, plus store data and a memory op code, over a valid/ready handshake. Drives a single-outstanding request/grant/response data-memory port. Returns aligned, sign- or zero-extended load data (or a store completion) to writeback over a second valid/ready handshake.

---
 rtl/ysyx_22050039_lsu_pkg.sv | 25 ++
 rtl/ysyx_22050039_lsu_align.sv | 54 +++++
 rtl/ysyx_22050039_lsu.sv | 120 ++++++++++++
 tb/tb_ysyx_22050039_lsu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Op field layout, size codes, lane masks and FSM states.
package ysyx_22050039_lsu_pkg;

    localparam int STORE_BIT    = 3;
    localparam int UNSIGNED_BIT = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// Byte-lane alignment for the LSU: store shift/mask,
// load shift/extension and misalignment detection.
module ysyx_22050039_lsu_align #(
    parameter int XLEN = 64
) (
    input  logic [1:0]      sz,
    input  logic            uns,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata_sh,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);
    import ysyx_22050039_lsu_pkg::*;

    logic [7:0]      base;
    logic [XLEN-1:0] r;

    always_comb begin
        base       = MASK_D;
        rdata_ext  = '0;
        misaligned = 1'b0;
        r          = rdata >> {off, 3'b000};
        wdata_sh   = wdata << {off, 3'b000};
        unique case (sz)
            SZ_B: begin
                base      = MASK_B;
                rdata_ext = uns ? {{(XLEN-8){1'b0}}, r[7:0]}
                                : {{(XLEN-8){r[7]}}, r[7:0]};
            end
            SZ_H: begin
                base       = MASK_H;
                misaligned = off[0];
                rdata_ext  = uns ? {{(XLEN-16){1'b0}}, r[15:0]}
                                 : {{(XLEN-16){r[15]}}, r[15:0]};
            end
            SZ_W: begin
                base       = MASK_W;
                misaligned = |off[1:0];
                rdata_ext  = uns ? {{(XLEN-32){1'b0}}, r[31:0]}
                                 : {{(XLEN-32){r[31]}}, r[31:0]};
            end
            SZ_D: begin
                base       = MASK_D;
                misaligned = |off;
                rdata_ext  = r;
            end
        endcase
        wmask = base << off;
    end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit between EXU and writeback.
// Single outstanding request on a req/gnt/rvalid memory port.
module ysyx_22050039_lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_err
);
    import ysyx_22050039_lsu_pkg::*;

    lsu_state_e      state, state_nx;
    logic [3:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;

    logic            idle;
    logic [3:0]      a_op;
    logic [XLEN-1:0] a_addr;
    logic [XLEN-1:0] a_wdata;
    logic [XLEN-1:0] a_wsh;
    logic [7:0]      a_mask;
    logic [XLEN-1:0] a_rext;
    logic            a_mis;
    logic            is_req;
    logic            is_st;
    logic            is_resp;

    // In IDLE the aligner looks at the incoming op to flag misalignment;
    // afterwards it works on the captured op.
    assign idle    = (state == S_IDLE);
    assign a_op    = idle ? in_op    : op_q;
    assign a_addr  = idle ? in_addr  : addr_q;
    assign a_wdata = idle ? in_wdata : wdata_q;

    ysyx_22050039_lsu_align #(.XLEN(XLEN)) u_align (
        .sz         (a_op[1:0]),
        .uns        (a_op[UNSIGNED_BIT]),
        .off        (a_addr[2:0]),
        .wdata      (a_wdata),
        .rdata      (mem_rdata),
        .wdata_sh   (a_wsh),
        .wmask      (a_mask),
        .rdata_ext  (a_rext),
        .misaligned (a_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid)   state_nx = a_mis ? S_RESP : S_REQ;
            S_REQ:  if (mem_gnt)    state_nx = S_WAIT;
            S_WAIT: if (mem_rvalid) state_nx = S_RESP;
            S_RESP: if (out_ready)  state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (idle && in_valid) begin
            op_q    <= in_op;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rd_q    <= in_rd;
            data_q  <= '0;
            err_q   <= a_mis;
        end else if (state == S_WAIT && mem_rvalid && !op_q[STORE_BIT]) begin
            data_q  <= a_rext;
        end
    end

    assign is_req  = (state == S_REQ);
    assign is_st   = op_q[STORE_BIT];
    assign is_resp = (state == S_RESP);

    assign in_ready  = idle;
    assign mem_req   = is_req;
    assign mem_we    = is_req && is_st;
    assign mem_addr  = is_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_wdata = (is_req && is_st) ? a_wsh : '0;
    assign mem_wmask = (is_req && is_st) ? a_mask : 8'h00;
    assign out_valid = is_resp;
    assign out_data  = is_resp ? data_q : '0;
    assign out_rd    = is_resp ? rd_q : 5'd0;
    assign out_err   = is_resp && err_q;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed self-checking bench for ysyx_22050039_lsu.
// Inputs driven and outputs sampled on the falling edge.
module tb_ysyx_22050039_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ysyx_22050039_lsu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_err(out_err)
    );

    // Runs one op against a zero-wait memory; reports what was observed.
    task automatic txn(
        input  logic [3:0]  op,
        input  logic [63:0] addr,
        input  logic [63:0] wdata,
        input  logic [4:0]  rd,
        input  logic [63:0] rdata,
        output logic        o_req,
        output logic        o_we,
        output logic [63:0] o_maddr,
        output logic [63:0] o_mwdata,
        output logic [7:0]  o_mask,
        output logic        o_vld,
        output logic [63:0] o_data,
        output logic        o_err,
        output logic [4:0]  o_rd
    );
        o_req = 0; o_we = 0; o_maddr = '0; o_mwdata = '0; o_mask = '0;
        @(negedge clk);
        in_valid = 1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
        @(negedge clk);
        in_valid = 0;
        if (mem_req) begin
            o_req = 1; o_we = mem_we; o_maddr = mem_addr;
            o_mwdata = mem_wdata; o_mask = mem_wmask;
            mem_gnt = 1;
            @(negedge clk);
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = rdata;
            @(negedge clk);
            mem_rvalid = 0;
        end
        o_vld = out_valid; o_data = out_data; o_err = out_err; o_rd = out_rd;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        total++; if ({mem_req, mem_we, mem_wmask} !== 10'd0) begin bad++; $display("FAIL rst_mem_ctl got %b exp 0", {mem_req, mem_we, mem_wmask}); end
        total++; if ({mem_addr, mem_wdata} !== 128'd0) begin bad++; $display("FAIL rst_mem_bus got %h exp 0", {mem_addr, mem_wdata}); end
        total++; if ({out_valid, out_err, out_rd, out_data} !== 71'd0) begin bad++; $display("FAIL rst_out got %h exp 0", {out_valid, out_err, out_rd, out_data}); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_loads();
        logic rq, we, v, e; logic [63:0] ma, mw, d; logic [7:0] mk; logic [4:0] r;
        txn(4'h0, 64'h8000_0005, 0, 5'd3, 64'h1122_33F4_5566_7788, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (ma !== 64'h8000_0000) begin bad++; $display("FAIL lb5_addr got %h exp 80000000", ma); end
        total++; if ({rq, we, mk} !== 10'b10_0000_0000) begin bad++; $display("FAIL lb5_ctl got %b exp 1000000000", {rq, we, mk}); end
        total++; if ({v, e, r} !== 7'b10_00011) begin bad++; $display("FAIL lb5_resp got %b exp 1000011", {v, e, r}); end
        total++; if (d !== 64'h33) begin bad++; $display("FAIL lb5_data got %h exp 33", d); end
        txn(4'h0, 64'h8000_0004, 0, 5'd4, 64'h1122_33F4_5566_7788, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'hFFFF_FFFF_FFFF_FFF4 || e !== 1'b0) begin bad++; $display("FAIL lb_sext got %h/%b exp fffffffffffffff4/0", d, e); end
        txn(4'h4, 64'h8000_0004, 0, 5'd4, 64'h1122_33F4_5566_7788, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'hF4) begin bad++; $display("FAIL lbu_zext got %h exp f4", d); end
        txn(4'h2, 64'h8000_0004, 0, 5'd5, 64'h8765_4321_0000_0000, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'hFFFF_FFFF_8765_4321) begin bad++; $display("FAIL lw_sext got %h exp ffffffff87654321", d); end
        txn(4'h6, 64'h8000_0004, 0, 5'd5, 64'h8765_4321_0000_0000, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'h8765_4321) begin bad++; $display("FAIL lwu_zext got %h exp 87654321", d); end
        txn(4'h5, 64'h8000_0002, 0, 5'd6, 64'h0000_0000_9ABC_0000, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'h9ABC || e !== 1'b0) begin bad++; $display("FAIL lhu_off2 got %h/%b exp 9abc/0", d, e); end
        txn(4'h7, 64'h8000_0008, 0, 5'd8, 64'hDEAD_BEEF_CAFE_F00D, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (d !== 64'hDEAD_BEEF_CAFE_F00D || ma !== 64'h8000_0008) begin bad++; $display("FAIL ld_u got %h@%h exp deadbeefcafef00d@80000008", d, ma); end
    endtask

    task automatic test_stores();
        logic rq, we, v, e; logic [63:0] ma, mw, d; logic [7:0] mk; logic [4:0] r;
        txn(4'h9, 64'h8000_0006, 64'hAAAA_BBBB_CCCC_1234, 5'd1, 64'hFFFF, rq, we, ma, mw, mk, v, d, e, r);
        total++; if ({rq, we, mk} !== 10'b11_1100_0000) begin bad++; $display("FAIL sh_ctl got %b exp 1111000000", {rq, we, mk}); end
        total++; if (mw !== 64'h1234_0000_0000_0000 || ma !== 64'h8000_0000) begin bad++; $display("FAIL sh_bus got %h@%h exp 1234000000000000@80000000", mw, ma); end
        total++; if ({v, e, d} !== {2'b10, 64'd0}) begin bad++; $display("FAIL sh_resp got %b/%b/%h exp 1/0/0", v, e, d); end
        txn(4'h8, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd2, 64'h0, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (mk !== 8'h08 || mw !== 64'hAB00_0000) begin bad++; $display("FAIL sb got %h/%h exp 08/ab000000", mk, mw); end
        txn(4'hB, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 5'd2, 64'h0, rq, we, ma, mw, mk, v, d, e, r);
        total++; if (mk !== 8'hFF || mw !== 64'h0123_4567_89AB_CDEF || ma !== 64'h8000_0010) begin bad++; $display("FAIL sd got %h/%h@%h exp ff/0123456789abcdef@80000010", mk, mw, ma); end
    endtask

    task automatic test_misaligned();
        logic rq, we, v, e; logic [63:0] ma, mw, d; logic [7:0] mk; logic [4:0] r;
        txn(4'h2, 64'h8000_0002, 0, 5'd9, 64'h1234, rq, we, ma, mw, mk, v, d, e, r);
        total++; if ({rq, v, e, r} !== 8'b0_1_1_01001 || d !== 64'd0) begin bad++; $display("FAIL mis_w got req=%b v=%b e=%b rd=%0d d=%h exp 0 1 1 9 0", rq, v, e, r, d); end
        txn(4'h1, 64'h8000_0001, 0, 5'd9, 64'h1234, rq, we, ma, mw, mk, v, d, e, r);
        total++; if ({rq, v, e} !== 3'b011) begin bad++; $display("FAIL mis_h got %b exp 011", {rq, v, e}); end
        txn(4'hB, 64'h8000_0004, 64'h55, 5'd9, 64'h1234, rq, we, ma, mw, mk, v, d, e, r);
        total++; if ({rq, v, e} !== 3'b011 || d !== 64'd0) begin bad++; $display("FAIL mis_sd got %b/%h exp 011/0", {rq, v, e}, d); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mis_idle got %b%b exp 10", in_ready, out_valid); end
    endtask

    task automatic test_stalls();
        @(negedge clk);
        in_valid = 1; in_op = 4'h3; in_addr = 64'h8000_0018; in_rd = 5'd7;
        @(negedge clk);
        in_op = 4'hB; in_addr = 64'h8000_0100; in_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            total++; if ({mem_req, mem_we, mem_wmask, in_ready} !== 11'b1_0_00000000_0 || mem_addr !== 64'h8000_0018) begin bad++; $display("FAIL gnt_stall%0d got %b@%h exp 10000000000@80000018", i, {mem_req, mem_we, mem_wmask, in_ready}, mem_addr); end
            @(negedge clk);
        end
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'hBAD;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0018) begin bad++; $display("FAIL gnt_cycle got %b@%h exp 1@80000018", mem_req, mem_addr); end
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        total++; if ({mem_req, out_valid, in_ready} !== 3'b000) begin bad++; $display("FAIL early_rvalid got %b exp 000", {mem_req, out_valid, in_ready}); end
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 64'h0011_2233_4455_6677;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = 64'hFFFF;
        for (int i = 0; i < 2; i++) begin
            total++; if ({out_valid, in_ready, out_rd} !== 7'b1_0_00111 || out_data !== 64'h0011_2233_4455_6677) begin bad++; $display("FAIL bp_stall%0d got %b/%h exp 1000111/0011223344556677", i, {out_valid, in_ready, out_rd}, out_data); end
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        total++; if (out_valid !== 1'b1 || out_data !== 64'h0011_2233_4455_6677) begin bad++; $display("FAIL bp_last got %b/%h exp 1/0011223344556677", out_valid, out_data); end
        @(negedge clk);
        out_ready = 0;
        total++; if ({in_ready, out_valid, mem_req} !== 3'b100) begin bad++; $display("FAIL bp_idle got %b exp 100", {in_ready, out_valid, mem_req}); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1; in_op = 4'h3; in_addr = 64'h8000_0020; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ar_req_pre got %b exp 1", mem_req); end
        #2 rst = 0;
        #1;
        total++; if ({in_ready, mem_req, out_valid} !== 3'b100) begin bad++; $display("FAIL ar_req got %b exp 100", {in_ready, mem_req, out_valid}); end
        @(negedge clk); rst = 1;
        in_valid = 1; in_op = 4'h3; in_addr = 64'h8000_0028; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #2 rst = 0;
        #1;
        total++; if ({in_ready, mem_req, out_valid} !== 3'b100) begin bad++; $display("FAIL ar_wait got %b exp 100", {in_ready, mem_req, out_valid}); end
        @(negedge clk); rst = 1;
        mem_rvalid = 1; mem_rdata = 64'h77;
        @(negedge clk);
        mem_rvalid = 0;
        total++; if ({out_valid, in_ready, out_data} !== {2'b01, 64'd0}) begin bad++; $display("FAIL ar_late_rvalid got %b%b/%h exp 01/0", out_valid, in_ready, out_data); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_stalls();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
